// File: rtl/max_pool_pkg.sv
`default_nettype none
// ============================================================================
// Module   : max_pool_pkg
// Brief    : Shared encodings and width helper for the max-pool item packer.
// Revision : 1.0 - initial release
// ============================================================================
package max_pool_pkg;

    localparam logic [1:0] STEP_1   = 2'b00;
    localparam logic [1:0] STEP_2   = 2'b01;
    localparam logic [1:0] STEP_4   = 2'b10;
    localparam logic [1:0] STEP_RSV = 2'b11;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    // Ceiling log2; value 1 yields 0.
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned bits;
        bits = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            bits++;
        end
        return bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/max_pool_item_compactor.sv
`default_nettype none
// ============================================================================
// Module   : max_pool_item_compactor
// Brief    : Gathers the selected items of an (N+1)-item group into the low
//            lanes in ascending index order and reports how many were taken.
// Revision : 1.0 - initial release
// ============================================================================
module max_pool_item_compactor #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic [(N+1)*W-1:0] i_items,
    input  logic [N:0]         i_mask,
    output logic [(N+1)*W-1:0] o_items,
    output logic [CW-1:0]      o_count
);

    // Running popcount of the mask gives each kept item its output lane.
    always_comb begin
        o_items = '0;
        o_count = '0;
        for (int i = 0; i <= N; i++) begin
            if (i_mask[i]) begin
                o_items[o_count*W +: W] = i_items[i*W +: W];
                o_count = o_count + CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/max_pool_item_packer.sv
`default_nettype none
// ============================================================================
// Module   : max_pool_item_packer
// Brief    : Selects stride-valid items from each (N+1)-item pooling group and
//            packs them densely into N-item output beats via a residual buffer.
//            Optional sticky error output enabled by MAX_POOL_PACKER_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module max_pool_item_packer
    import max_pool_pkg::*;
#(
    parameter int FEATURE_N_PER_CLK  = 4,
    parameter int FEATURE_DATA_WIDTH = 8,
    parameter int SIMULATION_DELAY   = 1
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic [1:0]                                            step_type,
    input  logic [(FEATURE_N_PER_CLK+1)*FEATURE_DATA_WIDTH-1:0]   s_axis_data,
    input  logic [(FEATURE_N_PER_CLK+1)*FEATURE_DATA_WIDTH/8-1:0] s_axis_keep,
    input  logic [2:0]                                            s_axis_user,
    input  logic                                                  s_axis_last,
    input  logic                                                  s_axis_valid,
    output logic                                                  s_axis_ready,
    output logic [FEATURE_N_PER_CLK*FEATURE_DATA_WIDTH-1:0]       m_axis_data,
    output logic [FEATURE_N_PER_CLK*FEATURE_DATA_WIDTH/8-1:0]     m_axis_keep,
    output logic [2:0]                                            m_axis_user,
    output logic                                                  m_axis_last,
    output logic                                                  m_axis_valid,
    input  logic                                                  m_axis_ready
`ifdef MAX_POOL_PACKER_ERR_EN
    ,
    output logic                                                  err_sticky
`endif
);

    localparam int c_N  = FEATURE_N_PER_CLK;
    localparam int c_W  = FEATURE_DATA_WIDTH;
    localparam int c_B  = c_W / 8;
    localparam int c_CW = int'(clogb2(2 * c_N + 1));
    localparam logic [c_CW-1:0] c_N_CNT = c_CW'(c_N);
    localparam bit c_cfg_ok = (c_N >= 2) && ((c_N & (c_N - 1)) == 0) &&
                              (c_W > 0) && ((c_W % 8) == 0) && (SIMULATION_DELAY >= 0);

    generate
        if (!c_cfg_ok) begin : g_cfg_check
            $error("max_pool_item_packer: illegal parameter combination");
        end
    endgenerate

    logic [0:0]               r_state;
    logic [0:0]               w_state_nxt;
    logic [c_N*c_W-1:0]       r_res;
    logic [c_CW-1:0]          r_res_cnt;
    logic [2:0]               r_hold_user;
    logic                     r_m_valid;
    logic [c_N*c_W-1:0]       r_m_data;
    logic [c_N*c_B-1:0]       r_m_keep;
    logic [2:0]               r_m_user;
    logic                     r_m_last;

    logic [c_N:0]             w_sel_mask;
    logic [(c_N+1)*c_W-1:0]   w_new_items;
    logic [c_CW-1:0]          w_new_cnt;
    logic [2*c_N*c_W-1:0]     w_new_ext;
    logic [2*c_N*c_W-1:0]     w_res_ext;
    logic [2*c_N*c_W-1:0]     w_comb;
    logic [c_CW-1:0]          w_total;
    logic                     w_slot_free;
    logic                     w_s_ready;
    logic                     w_in_hs;
    logic                     w_produce;
    logic [c_N*c_W-1:0]       w_emit_data;
    logic [c_CW-1:0]          w_emit_cnt;
    logic [c_N*c_B-1:0]       w_emit_keep;
    logic                     w_emit_last;
    logic [2:0]               w_emit_user;
    logic [c_N*c_W-1:0]       w_res_nxt;
    logic [c_CW-1:0]          w_res_cnt_nxt;
    logic [2:0]               w_hold_user_nxt;

    assign w_slot_free = !r_m_valid || m_axis_ready;
    assign w_s_ready   = (r_state == ST_RUN) && w_slot_free;
    assign w_in_hs     = s_axis_valid && w_s_ready;

    // An item is kept when its stride position qualifies and its first keep byte is set.
    always_comb begin
        w_sel_mask = '0;
        for (int i = 0; i <= c_N; i++) begin
            case (step_type)
                STEP_2:           w_sel_mask[i] = s_axis_keep[i*c_B] && ((i % 2) == 1);
                STEP_4:           w_sel_mask[i] = s_axis_keep[i*c_B] && ((i % 4) == 3);
                STEP_1, STEP_RSV: w_sel_mask[i] = s_axis_keep[i*c_B];
            endcase
        end
    end

    max_pool_item_compactor #(
        .N  (c_N),
        .W  (c_W),
        .CW (c_CW)
    ) u_compactor (
        .i_items (s_axis_data),
        .i_mask  (w_sel_mask),
        .o_items (w_new_items),
        .o_count (w_new_cnt)
    );

    // Combined stream: residual items in the low lanes, new items directly after.
    always_comb begin
        w_res_ext = '0;
        for (int i = 0; i < c_N; i++) begin
            if (i < int'(r_res_cnt)) begin
                w_res_ext[i*c_W +: c_W] = r_res[i*c_W +: c_W];
            end
        end
        w_new_ext = {{((c_N - 1) * c_W){1'b0}}, w_new_items};
        w_comb    = (w_new_ext << (int'(r_res_cnt) * c_W)) | w_res_ext;
    end

    assign w_total = r_res_cnt + w_new_cnt;

    always_comb begin
        w_state_nxt     = r_state;
        w_produce       = 1'b0;
        w_emit_data     = w_comb[c_N*c_W-1:0];
        w_emit_cnt      = c_N_CNT;
        w_emit_last     = 1'b0;
        w_emit_user     = s_axis_user;
        w_res_nxt       = r_res;
        w_res_cnt_nxt   = r_res_cnt;
        w_hold_user_nxt = r_hold_user;
        case (r_state)
            ST_RUN: begin
                if (w_in_hs) begin
                    if (s_axis_last && (w_total <= c_N_CNT)) begin
                        w_produce     = 1'b1;
                        w_emit_cnt    = w_total;
                        w_emit_last   = 1'b1;
                        w_res_cnt_nxt = '0;
                    end else if (s_axis_last) begin
                        // Overflow on the last group: the remainder leaves in one extra beat.
                        w_produce       = 1'b1;
                        w_res_nxt       = w_comb[2*c_N*c_W-1 -: c_N*c_W];
                        w_res_cnt_nxt   = w_total - c_N_CNT;
                        w_hold_user_nxt = s_axis_user;
                        w_state_nxt     = ST_FLUSH;
                    end else if (w_total >= c_N_CNT) begin
                        w_produce     = 1'b1;
                        w_res_nxt     = w_comb[2*c_N*c_W-1 -: c_N*c_W];
                        w_res_cnt_nxt = w_total - c_N_CNT;
                    end else begin
                        w_res_nxt     = w_comb[c_N*c_W-1:0];
                        w_res_cnt_nxt = w_total;
                    end
                end
            end
            ST_FLUSH: begin
                if (w_slot_free) begin
                    w_produce     = 1'b1;
                    w_emit_data   = r_res;
                    w_emit_cnt    = r_res_cnt;
                    w_emit_last   = 1'b1;
                    w_emit_user   = r_hold_user;
                    w_res_cnt_nxt = '0;
                    w_state_nxt   = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        w_emit_keep = '0;
        for (int b = 0; b < c_N * c_B; b++) begin
            w_emit_keep[b] = (b / c_B) < int'(w_emit_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res       <= '0;
            r_res_cnt   <= '0;
            r_hold_user <= '0;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
            r_m_keep    <= '0;
            r_m_user    <= '0;
            r_m_last    <= 1'b0;
        end else begin
            r_res       <= w_res_nxt;
            r_res_cnt   <= w_res_cnt_nxt;
            r_hold_user <= w_hold_user_nxt;
            if (w_produce) begin
                r_m_valid <= 1'b1;
                r_m_data  <= w_emit_data;
                r_m_keep  <= w_emit_keep;
                r_m_user  <= w_emit_user;
                r_m_last  <= w_emit_last;
            end else if (m_axis_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign s_axis_ready = w_s_ready;
    assign m_axis_valid = r_m_valid;
    assign m_axis_data  = r_m_data;
    assign m_axis_keep  = r_m_keep;
    assign m_axis_user  = r_m_user;
    assign m_axis_last  = r_m_last;

`ifdef MAX_POOL_PACKER_ERR_EN
    logic r_err_sticky;
    logic w_keep_bad;

    always_comb begin
        w_keep_bad = 1'b0;
        for (int i = 0; i <= c_N; i++) begin
            if ((&s_axis_keep[i*c_B +: c_B]) != (|s_axis_keep[i*c_B +: c_B])) begin
                w_keep_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_sticky <= 1'b0;
        end else if (w_in_hs && ((step_type == STEP_RSV) || w_keep_bad)) begin
            r_err_sticky <= 1'b1;
        end
    end

    assign err_sticky = r_err_sticky;
`endif

endmodule
`default_nettype wire

// File: tb/tb_max_pool_item_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_max_pool_item_packer
// Brief    : Self-checking bench for max_pool_item_packer (N=4, W=8) against a
//            queue-based item-stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_max_pool_item_packer;

    localparam int N = 4;
    localparam int W = 8;

    typedef struct {
        logic [N*W-1:0] data;
        int             cnt;
        bit             last;
        logic [2:0]     user;
    } exp_t;

    typedef struct {
        logic [N*W-1:0] data;
        logic [N-1:0]   keep;
        bit             last;
        logic [2:0]     user;
    } obs_t;

    logic               clk;
    logic               rst;
    logic [1:0]         step_type;
    logic [(N+1)*W-1:0] s_axis_data;
    logic [N:0]         s_axis_keep;
    logic [2:0]         s_axis_user;
    logic               s_axis_last;
    logic               s_axis_valid;
    logic               s_axis_ready;
    logic [N*W-1:0]     m_axis_data;
    logic [N-1:0]       m_axis_keep;
    logic [2:0]         m_axis_user;
    logic               m_axis_last;
    logic               m_axis_valid;
    logic               m_axis_ready;

    exp_t       exp_q[$];
    obs_t       obs_q[$];
    logic [W-1:0] pend_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         rdy_mode = 0;
    int         stall_cnt = 0;

    max_pool_item_packer #(
        .FEATURE_N_PER_CLK  (N),
        .FEATURE_DATA_WIDTH (W),
        .SIMULATION_DELAY   (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .step_type    (step_type),
        .s_axis_data  (s_axis_data),
        .s_axis_keep  (s_axis_keep),
        .s_axis_user  (s_axis_user),
        .s_axis_last  (s_axis_last),
        .s_axis_valid (s_axis_valid),
        .s_axis_ready (s_axis_ready),
        .m_axis_data  (m_axis_data),
        .m_axis_keep  (m_axis_keep),
        .m_axis_user  (m_axis_user),
        .m_axis_last  (m_axis_last),
        .m_axis_valid (m_axis_valid),
        .m_axis_ready (m_axis_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Reference: a flat queue of kept items, cut into N-item beats.
    function automatic void emit(input int cnt, input bit last, input logic [2:0] u);
        exp_t e;
        e.data = '0;
        for (int j = 0; j < cnt; j++) e.data[j*W +: W] = pend_q.pop_front();
        e.cnt  = cnt;
        e.last = last;
        e.user = u;
        exp_q.push_back(e);
    endfunction

    function automatic void model_in(input logic [(N+1)*W-1:0] d, input logic [N:0] k,
                                     input logic [2:0] u, input bit last, input logic [1:0] step);
        for (int i = 0; i <= N; i++) begin
            bit cand;
            case (step)
                2'b01:   cand = (i % 2) == 1;
                2'b10:   cand = (i % 4) == 3;
                default: cand = 1'b1;
            endcase
            if (cand && k[i]) pend_q.push_back(d[i*W +: W]);
        end
        if (!last) begin
            if (pend_q.size() >= N) emit(N, 1'b0, u);
        end else begin
            if (pend_q.size() > N) emit(N, 1'b0, u);
            emit(pend_q.size(), 1'b1, u);
        end
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [(N+1)*W-1:0] d, input logic [N:0] k,
                        input logic [2:0] u, input bit last, input logic [1:0] step);
        int waited;
        waited       = 0;
        s_axis_data  = d;
        s_axis_keep  = k;
        s_axis_user  = u;
        s_axis_last  = last;
        step_type    = step;
        s_axis_valid = 1'b1;
        @(negedge clk);
        while (!s_axis_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (s_axis_ready) begin
            model_in(d, k, u, last, step);
        end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: s_axis_ready=%0b after %0d clks, required 1", s_axis_ready, waited);
        end
        @(posedge clk);
        #1;
        s_axis_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || m_axis_valid) && w < 300) begin
            @(posedge clk);
            w++;
        end
        #1;
        chk("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        m_axis_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       m_axis_ready = 1'b1;
                1:       m_axis_ready = ($urandom_range(0, 2) != 0);
                default: m_axis_ready = 1'b0;
            endcase
        end
    end

    // Output checker: every accepted beat against the model, plus hold-stability.
    initial begin
        logic [N*W-1:0] p_data;
        logic [N-1:0]   p_keep;
        logic           p_last;
        logic [2:0]     p_user;
        bit             p_stall;
        p_stall = 1'b0;
        p_data  = '0;
        p_keep  = '0;
        p_last  = 1'b0;
        p_user  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                p_stall = 1'b0;
            end else begin
                if (p_stall) begin
                    logic [N*W-1:0] msk;
                    msk = '0;
                    for (int j = 0; j < N; j++) if (p_keep[j]) msk[j*W +: W] = '1;
                    chk("hold_valid", m_axis_valid, 1'b1);
                    chk("hold_keep", m_axis_keep, p_keep);
                    chk("hold_data", m_axis_data & msk, p_data & msk);
                    chk("hold_last", m_axis_last, p_last);
                    chk("hold_user", m_axis_user, p_user);
                end
                if (m_axis_valid && !m_axis_ready) begin
                    stall_cnt++;
                    chk("stall_s_ready", s_axis_ready, 1'b0);
                end
                if (m_axis_valid && m_axis_ready) begin
                    obs_t o;
                    o.data = m_axis_data;
                    o.keep = m_axis_keep;
                    o.last = m_axis_last;
                    o.user = m_axis_user;
                    obs_q.push_back(o);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_beat: got beat keep=%0h last=%0b, required no beat",
                                 m_axis_keep, m_axis_last);
                    end else begin
                        exp_t e;
                        logic [N*W-1:0] msk;
                        logic [N-1:0]   ek;
                        e   = exp_q.pop_front();
                        msk = '0;
                        ek  = '0;
                        for (int j = 0; j < e.cnt; j++) begin
                            msk[j*W +: W] = '1;
                            ek[j]         = 1'b1;
                        end
                        chk("beat_keep", m_axis_keep, ek);
                        chk("beat_data", m_axis_data & msk, e.data);
                        chk("beat_last", m_axis_last, e.last);
                        chk("beat_user", m_axis_user, e.user);
                    end
                end
                p_stall = m_axis_valid && !m_axis_ready;
                p_data  = m_axis_data;
                p_keep  = m_axis_keep;
                p_last  = m_axis_last;
                p_user  = m_axis_user;
            end
        end
    end

    initial begin
        rst          = 1'b1;
        step_type    = 2'b00;
        s_axis_data  = '0;
        s_axis_keep  = '0;
        s_axis_user  = '0;
        s_axis_last  = 1'b0;
        s_axis_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", m_axis_valid, 1'b0);
        chk("rst_m_last", m_axis_last, 1'b0);
        chk("rst_m_keep", m_axis_keep, '0);
        chk("rst_m_data", m_axis_data, '0);
        chk("rst_m_user", m_axis_user, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_s_ready", s_axis_ready, 1'b1);

        // stride1, 15 items: 4,4,4 then a 3-item flush
        obs_q.delete();
        for (int b = 0; b < 3; b++) begin
            logic [(N+1)*W-1:0] d;
            for (int i = 0; i <= N; i++) d[i*W +: W] = 8'(b * 16 + i);
            send(d, 5'b11111, 3'(b + 1), b == 2, 2'b00);
        end
        chk("flush_s_ready", s_axis_ready, 1'b0);
        drain();
        chk("t1_beats", obs_q.size(), 4);
        if (obs_q.size() == 4) begin
            chk("t1_keep0", obs_q[0].keep, 4'hF);
            chk("t1_keep2", obs_q[2].keep, 4'hF);
            chk("t1_last2", obs_q[2].last, 1'b0);
            chk("t1_keep3", obs_q[3].keep, 4'h7);
            chk("t1_last3", obs_q[3].last, 1'b1);
            chk("t1_data3", obs_q[3].data[23:0], 24'h242322);
            chk("t1_user3", obs_q[3].user, 3'd3);
        end

        // stride2: two beats {4,3,2,1,0} -> {3,1,3,1}
        obs_q.delete();
        send(40'h04_03_02_01_00, 5'b11111, 3'd0, 1'b0, 2'b01);
        send(40'h04_03_02_01_00, 5'b11111, 3'd5, 1'b1, 2'b01);
        drain();
        chk("t2_beats", obs_q.size(), 1);
        if (obs_q.size() == 1) begin
            chk("t2_data", obs_q[0].data, 32'h03_01_03_01);
            chk("t2_keep", obs_q[0].keep, 4'hF);
            chk("t2_last", obs_q[0].last, 1'b1);
        end

        // stride4: only item 3 survives
        obs_q.delete();
        send(40'h00_A5_00_00_00, 5'b11111, 3'd7, 1'b1, 2'b10);
        drain();
        chk("t3_beats", obs_q.size(), 1);
        if (obs_q.size() == 1) begin
            chk("t3_keep", obs_q[0].keep, 4'b0001);
            chk("t3_data", obs_q[0].data[7:0], 8'hA5);
            chk("t3_last", obs_q[0].last, 1'b1);
        end

        // sparse masks 10101 then 01010 -> {0,2,4,1} then {3}
        obs_q.delete();
        send(40'h04_03_02_01_00, 5'b10101, 3'd1, 1'b0, 2'b00);
        send(40'h04_03_02_01_00, 5'b01010, 3'd2, 1'b1, 2'b00);
        drain();
        chk("t4_beats", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            chk("t4_data0", obs_q[0].data, 32'h01_04_02_00);
            chk("t4_last0", obs_q[0].last, 1'b0);
            chk("t4_keep1", obs_q[1].keep, 4'b0001);
            chk("t4_data1", obs_q[1].data[7:0], 8'h03);
            chk("t4_last1", obs_q[1].last, 1'b1);
        end

        // backpressure: output held off for 5 clks mid-stream
        stall_cnt = 0;
        send({8'h15, 8'h14, 8'h13, 8'h12, 8'h11}, 5'b11111, 3'd1, 1'b0, 2'b00);
        rdy_mode = 2;
        fork
            send({8'h25, 8'h24, 8'h23, 8'h22, 8'h21}, 5'b11111, 3'd2, 1'b0, 2'b00);
            begin
                repeat (5) @(posedge clk);
                #1;
                rdy_mode = 0;
            end
        join
        send({8'h35, 8'h34, 8'h33, 8'h32, 8'h31}, 5'b11011, 3'd3, 1'b1, 2'b00);
        drain();
        chk("t5_stall_seen", stall_cnt >= 3, 1'b1);

        // empty last beat with nothing buffered
        obs_q.delete();
        send(40'h0, 5'b00000, 3'd4, 1'b1, 2'b00);
        drain();
        chk("t6_beats", obs_q.size(), 1);
        if (obs_q.size() == 1) begin
            chk("t6_keep", obs_q[0].keep, 4'b0000);
            chk("t6_last", obs_q[0].last, 1'b1);
        end

        // reset mid-packet discards the pending beat and the residual
        rdy_mode = 2;
        send({8'h45, 8'h44, 8'h43, 8'h42, 8'h41}, 5'b11111, 3'd6, 1'b0, 2'b00);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pend_q.delete();
        exp_q.delete();
        chk("t7_valid_after_rst", m_axis_valid, 1'b0);
        rdy_mode = 0;
        obs_q.delete();
        send(40'h0, 5'b00000, 3'd2, 1'b1, 2'b00);
        drain();
        chk("t7_beats", obs_q.size(), 1);
        if (obs_q.size() == 1) begin
            chk("t7_keep", obs_q[0].keep, 4'b0000);
            chk("t7_last", obs_q[0].last, 1'b1);
        end

        // randomized packets under random backpressure
        rdy_mode = 1;
        for (int p = 0; p < 40; p++) begin
            int          len;
            logic [1:0]  st;
            len = $urandom_range(1, 6);
            st  = 2'($urandom_range(0, 3));
            for (int b = 0; b < len; b++) begin
                logic [(N+1)*W-1:0] d;
                logic [N:0]         k;
                d = {8'($urandom), 32'($urandom)};
                k = ($urandom_range(0, 3) == 0) ? 5'b11111 : 5'($urandom);
                send(d, k, 3'($urandom), b == len - 1, st);
            end
        end
        rdy_mode = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
